// File: rtl/score_pkg.sv
// Shared definitions for the HUD score renderer: game state codes,
// glyph cell geometry and the 5x7 decimal digit font.
package score_pkg;

    localparam int unsigned GLYPH_W = 5;
    localparam int unsigned GLYPH_H = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DYING = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    // One font pixel; rows are packed top to bottom, bit 4 of a row is x = 0.
    // Codes above 9 and coordinates outside the 5x7 cell are blank.
    function automatic logic glyph_px(input logic [3:0] digit,
                                      input logic [2:0] x,
                                      input logic [2:0] y);
        logic [34:0] bits;
        logic [4:0]  row;
        case (digit)
            4'd0: bits = {5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110};
            4'd1: bits = {5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
            4'd2: bits = {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111};
            4'd3: bits = {5'b11111, 5'b00010, 5'b00100, 5'b00010, 5'b00001, 5'b10001, 5'b01110};
            4'd4: bits = {5'b00010, 5'b00110, 5'b01010, 5'b10010, 5'b11111, 5'b00010, 5'b00010};
            4'd5: bits = {5'b11111, 5'b10000, 5'b11110, 5'b00001, 5'b00001, 5'b10001, 5'b01110};
            4'd6: bits = {5'b00110, 5'b01000, 5'b10000, 5'b11110, 5'b10001, 5'b10001, 5'b01110};
            4'd7: bits = {5'b11111, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b01000, 5'b01000};
            4'd8: bits = {5'b01110, 5'b10001, 5'b10001, 5'b01110, 5'b10001, 5'b10001, 5'b01110};
            4'd9: bits = {5'b01110, 5'b10001, 5'b10001, 5'b01111, 5'b00001, 5'b00010, 5'b01100};
            default: bits = '0;
        endcase
        if (x > 3'd4 || y > 3'd6) begin
            return 1'b0;
        end
        row = 5'(bits >> (5 * (6 - int'(y))));
        return row[3'd4 - x];
    endfunction

endpackage

// File: rtl/score_board_bcd_if.sv
// Bundle of raster, game-control and HUD output signals between the game
// core (master) and the score board (slave).
interface score_board_bcd_if #(
    parameter int unsigned DIGITS = 4
);
    logic [9:0]          h_cnt;
    logic [9:0]          v_cnt;
    logic                frame_tick;
    logic [2:0]          state;
    logic                clear;
    logic                inc;
    logic                commit;
    logic [4*DIGITS-1:0] score_bcd;
    logic [4*DIGITS-1:0] hs_bcd;
    logic                new_hs;
    logic                score_pixel;
    logic                hs_pixel;

    modport master (
        output h_cnt, v_cnt, frame_tick, state, clear, inc, commit,
        input  score_bcd, hs_bcd, new_hs, score_pixel, hs_pixel
    );

    modport slave (
        input  h_cnt, v_cnt, frame_tick, state, clear, inc, commit,
        output score_bcd, hs_bcd, new_hs, score_pixel, hs_pixel
    );
endinterface

// File: rtl/bcd_counter_sat.sv
// Multi-digit BCD up-counter that saturates at all nines, with a
// magnitude comparator against an external BCD value.
module bcd_counter_sat #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                inc_i,
    input  logic [4*DIGITS-1:0] cmp_i,
    output logic [4*DIGITS-1:0] value_o,
    output logic                gt_o
);

    logic [4*DIGITS-1:0] value_q;
    logic [4*DIGITS-1:0] value_d;
    logic [4*DIGITS-1:0] inc_val;
    logic [DIGITS:0]     carry;
    logic [DIGITS-1:0]   is_nine;

    // Ripple carry: a digit rolls 9->0 and passes the carry up only when
    // every digit below it is also 9.
    assign carry[0] = 1'b1;
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign is_nine[g]         = (value_q[4*g +: 4] == 4'd9);
        assign inc_val[4*g +: 4]  = !carry[g]  ? value_q[4*g +: 4] :
                                    is_nine[g] ? 4'd0 : value_q[4*g +: 4] + 4'd1;
        assign carry[g+1]         = carry[g] & is_nine[g];
    end

    // Next value: clear beats inc; a carry out of the top digit means all
    // nines, so the count holds instead of wrapping.
    always_comb begin
        value_d = value_q;
        if (clear_i) begin
            value_d = '0;
        end else if (inc_i && !carry[DIGITS]) begin
            value_d = inc_val;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    // Packed BCD with the most significant digit on top orders like binary.
    assign gt_o    = (value_q > cmp_i);
    assign value_o = value_q;

endmodule

// File: rtl/score_board_bcd.sv
// HUD score keeper: BCD score and high score, record flag with blink,
// and registered one-bit glyph pixel streams for both numbers.
module score_board_bcd
    import score_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned SCALE_LOG2   = 1,
    parameter int unsigned GAP          = 4,
    parameter int unsigned SC_X         = 550,
    parameter int unsigned SC_Y         = 20,
    parameter int unsigned HS_X         = 20,
    parameter int unsigned HS_Y         = 20,
    parameter int unsigned HS_OVER_X    = 120,
    parameter int unsigned HS_OVER_Y    = 140,
    parameter int unsigned BLINK_FRAMES = 16,
    parameter logic [2:0]  S_OVER       = ST_OVER
) (
    input  logic              clk,
    input  logic              rst,
    score_board_bcd_if.slave  bus
);

    localparam int unsigned CELL_W  = GLYPH_W << SCALE_LOG2;
    localparam int unsigned CELL_H  = GLYPH_H << SCALE_LOG2;
    localparam int unsigned PITCH   = CELL_W + GAP;
    localparam int unsigned FIELD_W = DIGITS * CELL_W + (DIGITS - 1) * GAP;
    localparam int unsigned FC_W    = $clog2(BLINK_FRAMES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [4*DIGITS-1:0] score;
    logic                score_gt;
    logic [4*DIGITS-1:0] hs_q, hs_d;
    logic                new_hs_q, new_hs_d;
    logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic                blink_on_q, blink_on_d;
    logic                score_pixel_q, score_pixel_d;
    logic                hs_pixel_q, hs_pixel_d;
    int unsigned         hs_x0, hs_y0;

    bcd_counter_sat #(
        .DIGITS (DIGITS)
    ) u_score (
        .clk     (clk),
        .rst     (rst),
        .clear_i (bus.clear),
        .inc_i   (bus.inc),
        .cmp_i   (hs_q),
        .value_o (score),
        .gt_o    (score_gt)
    );

    // Glyph pixel of a DIGITS-wide field whose top-left corner is (x0, y0);
    // gap columns and everything outside the field read as 0.
    function automatic logic field_px(input logic [9:0]          h,
                                      input logic [9:0]          v,
                                      input int unsigned         x0,
                                      input int unsigned         y0,
                                      input logic [4*DIGITS-1:0] val);
        int unsigned hx, vy, dx, dy, lo;
        logic        px;
        px = 1'b0;
        hx = {22'd0, h};
        vy = {22'd0, v};
        if (hx >= x0 && hx < x0 + FIELD_W && vy >= y0 && vy < y0 + CELL_H) begin
            dx = hx - x0;
            dy = vy - y0;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                lo = i * PITCH;
                if (dx >= lo && dx < lo + CELL_W) begin
                    px = glyph_px(4'(val >> (4 * (DIGITS - 1 - i))),
                                  3'((dx - lo) >> SCALE_LOG2),
                                  3'(dy >> SCALE_LOG2));
                end
            end
        end
        return px;
    endfunction

    // Commit compares the pre-increment score; only a strictly larger score
    // is a record. clear drops the record flag.
    always_comb begin
        hs_d     = hs_q;
        new_hs_d = new_hs_q;
        if (bus.commit && score_gt) begin
            hs_d     = score;
            new_hs_d = 1'b1;
        end
        if (bus.clear) begin
            new_hs_d = 1'b0;
        end
    end

    // High-score and record-flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q     <= '0;
            new_hs_q <= 1'b0;
        end else begin
            hs_q     <= hs_d;
            new_hs_q <= new_hs_d;
        end
    end

    // Frame counter wraps every BLINK_FRAMES ticks and flips the blink phase.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_on_d  = blink_on_q;
        if (bus.frame_tick) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
        end
    end

    // Blink phase registers; commit has no effect on them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    // Pixel lookups for the current raster position; the high-score field
    // moves to the game-over position and is blanked in the off blink phase
    // while a fresh record is flagged.
    always_comb begin
        hs_x0         = (bus.state == S_OVER) ? HS_OVER_X : HS_X;
        hs_y0         = (bus.state == S_OVER) ? HS_OVER_Y : HS_Y;
        score_pixel_d = field_px(bus.h_cnt, bus.v_cnt, SC_X, SC_Y, score);
        hs_pixel_d    = field_px(bus.h_cnt, bus.v_cnt, hs_x0, hs_y0, hs_q)
                        && (!new_hs_q || blink_on_q);
    end

    // Pixel output registers: one clock behind h_cnt/v_cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_pixel_q <= 1'b0;
            hs_pixel_q    <= 1'b0;
        end else begin
            score_pixel_q <= score_pixel_d;
            hs_pixel_q    <= hs_pixel_d;
        end
    end

    assign bus.score_bcd   = score;
    assign bus.hs_bcd      = hs_q;
    assign bus.new_hs      = new_hs_q;
    assign bus.score_pixel = score_pixel_q;
    assign bus.hs_pixel    = hs_pixel_q;

endmodule

// File: tb/tb_score_board_bcd.sv
// Directed bench for score_board_bcd: counting, saturation, commit rules,
// blink timing, glyph placement and reset behaviour.
module tb_score_board_bcd;
    import score_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    score_board_bcd_if #(.DIGITS(4)) bus ();

    score_board_bcd #(
        .DIGITS       (4),
        .SCALE_LOG2   (1),
        .GAP          (4),
        .SC_X         (550),
        .SC_Y         (20),
        .HS_X         (20),
        .HS_Y         (20),
        .HS_OVER_X    (120),
        .HS_OVER_Y    (140),
        .BLINK_FRAMES (16),
        .S_OVER       (3'd4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hold inc for n consecutive clock edges.
    task automatic run_inc(input int n);
        @(negedge clk);
        bus.inc = 1'b1;
        repeat (n) @(negedge clk);
        bus.inc = 1'b0;
    endtask

    // One-cycle pulse of any combination of the control inputs.
    task automatic pulse(input logic c, input logic i, input logic m, input logic t);
        @(negedge clk);
        bus.clear = c; bus.inc = i; bus.commit = m; bus.frame_tick = t;
        @(negedge clk);
        bus.clear = 1'b0; bus.inc = 1'b0; bus.commit = 1'b0; bus.frame_tick = 1'b0;
    endtask

    // Present a raster position and wait exactly one clock edge.
    task automatic px_at(input int h, input int v);
        @(negedge clk);
        bus.h_cnt = 10'(h);
        bus.v_cnt = 10'(v);
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        bus.h_cnt      = 10'd592;
        bus.v_cnt      = 10'd22;
        bus.frame_tick = 1'b0;
        bus.state      = ST_PLAY;
        bus.clear      = 1'b0;
        bus.inc        = 1'b0;
        bus.commit     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_score", 32'(bus.score_bcd), 32'h0);
        check("rst_hs", 32'(bus.hs_bcd), 32'h0);
        check("rst_new_hs", 32'(bus.new_hs), 32'h0);
        check("rst_score_px", 32'(bus.score_pixel), 32'h0);
        check("rst_hs_px", 32'(bus.hs_pixel), 32'h0);

        // Ones-digit '0' at x=0,y=1 is lit once rendering resumes.
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_px", 32'(bus.score_pixel), 32'h1);

        run_inc(1234);
        check("count_1234", 32'(bus.score_bcd), 32'h1234);
        check("count_new_hs", 32'(bus.new_hs), 32'h0);

        run_inc(8765);
        check("count_9999", 32'(bus.score_bcd), 32'h9999);
        run_inc(5);
        check("saturate", 32'(bus.score_bcd), 32'h9999);

        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check("clear_over_inc", 32'(bus.score_bcd), 32'h0);

        run_inc(500);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("hs_0500", 32'(bus.hs_bcd), 32'h0500);
        check("rec_0500", 32'(bus.new_hs), 32'h1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("clear_score", 32'(bus.score_bcd), 32'h0);
        check("clear_new_hs", 32'(bus.new_hs), 32'h0);
        check("clear_keeps_hs", 32'(bus.hs_bcd), 32'h0500);

        run_inc(499);
        check("score_0499", 32'(bus.score_bcd), 32'h0499);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        check("commit_inc_hs", 32'(bus.hs_bcd), 32'h0500);
        check("commit_inc_score", 32'(bus.score_bcd), 32'h0500);
        check("commit_inc_rec", 32'(bus.new_hs), 32'h0);

        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("equal_hs", 32'(bus.hs_bcd), 32'h0500);
        check("equal_rec", 32'(bus.new_hs), 32'h0);

        run_inc(231);
        check("score_0731", 32'(bus.score_bcd), 32'h0731);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("hs_0731", 32'(bus.hs_bcd), 32'h0731);
        check("rec_0731", 32'(bus.new_hs), 32'h1);

        // Leftmost hs digit '0' at x=0,y=1 is lit; it blinks with the record.
        px_at(20, 22);
        for (int k = 0; k < 40; k++) begin
            check($sformatf("blink_f%0d", k), 32'(bus.hs_pixel),
                  (k < 16 || k >= 32) ? 32'h1 : 32'h0);
            @(negedge clk);
            bus.frame_tick = 1'b1;
            bus.commit     = (k == 20);
            @(negedge clk);
            bus.frame_tick = 1'b0;
            bus.commit     = 1'b0;
            @(negedge clk);
        end
        check("blink_rec_kept", 32'(bus.new_hs), 32'h1);
        check("blink_hs_kept", 32'(bus.hs_bcd), 32'h0731);

        // Score 0001: inside rows 20..33 only the ones digit's x=4 column.
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        run_inc(1);
        check("score_0001", 32'(bus.score_bcd), 32'h0001);
        for (int v = 19; v <= 34; v++) begin
            for (int h = 590; h <= 603; h++) begin
                px_at(h, v);
                check($sformatf("sweep_h%0d_v%0d", h, v), 32'(bus.score_pixel),
                      (v >= 20 && v <= 33 && (h == 600 || h == 601)) ? 32'h1 : 32'h0);
            end
        end
        px_at(578, 22);
        check("tens_zero_px", 32'(bus.score_pixel), 32'h1);

        // Game over: hs field '0731' moves to (120,140).
        bus.state = ST_OVER;
        px_at(120, 142);
        check("over_hs_d0", 32'(bus.hs_pixel), 32'h1);
        px_at(20, 22);
        check("over_old_pos", 32'(bus.hs_pixel), 32'h0);
        px_at(142, 140);
        check("over_seven_top", 32'(bus.hs_pixel), 32'h1);
        px_at(134, 152);
        check("over_seven_btm", 32'(bus.hs_pixel), 32'h0);
        px_at(600, 20);
        check("over_score_px", 32'(bus.score_pixel), 32'h1);

        // Reset in the middle of a lit pixel clears outputs without a clock.
        bus.state = ST_PLAY;
        px_at(600, 22);
        check("pre_rst_px", 32'(bus.score_pixel), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_px", 32'(bus.score_pixel), 32'h0);
        check("mid_rst_score", 32'(bus.score_bcd), 32'h0);
        check("mid_rst_hs", 32'(bus.hs_bcd), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("resume_px", 32'(bus.score_pixel), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/score_board_bcd.md
# score_board_bcd

Parametrised BCD score keeper and pixel renderer for the game HUD.
- Counts score in BCD, tracks a high score, and flags and blinks a new record.
- Renders both numbers at configurable positions and scale as registered one-bit pixel streams, which feed the VGA colour mux.
- Replaces the fixed four-digit combinational score overlay.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits for score and high score (1–8)
- SCALE_LOG2, 1, glyph magnification; each 5×7 glyph cell is 2^SCALE_LOG2 pixels square
- GAP, 4, pixels between adjacent digits
- SC_X, 550, SC_Y, 20, top-left of the score field
- HS_X, 20, HS_Y, 20, top-left of the high-score field in play
- HS_OVER_X, 120, HS_OVER_Y, 140, top-left of the high-score field in the over state
- BLINK_FRAMES, 16, frames per blink half-period
- S_OVER, 3'd4, state encoding for game over

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- h_cnt  in  10  horizontal pixel counter
- v_cnt  in  10  vertical pixel counter
- frame_tick  in  1  one-cycle pulse per frame
- state  in  3  game state
- clear  in  1  zero the score (game start)
- inc  in  1  add one to the score
- commit  in  1  end of game: compare and latch the high score
- score_bcd  out  4*DIGITS  current score, digit 0 = ones in bits [3:0]
- hs_bcd  out  4*DIGITS  high score
- new_hs  out  1  last commit set a new record
- score_pixel  out  1  score glyph pixel
- hs_pixel  out  1  high-score glyph pixel

## Operation
Score:
- clear zeroes the score and clears new_hs.
- inc adds 1 with BCD ripple carry.
- At all-9s the score saturates; there is no wrap.
- clear has priority over inc.

Commit:
- commit compares the score register value before any same-cycle inc.
- If score > hs_bcd: hs_bcd ← score and new_hs ← 1. Otherwise both are unchanged.
- Equal scores do not set a record.
- A same-cycle inc is still applied to the score.

Blink:
- A frame counter advances on frame_tick.
- blink_on toggles every BLINK_FRAMES ticks.
- While new_hs = 1, hs_pixel is gated by blink_on; otherwise hs_pixel is ungated.

Render:
- Digit field width is DIGITS*(5<<S) + (DIGITS-1)*GAP, where S = SCALE_LOG2; height is 7<<S.
- Digits are drawn most significant leftmost.
- The high-score field uses the HS_OVER position when state == S_OVER, otherwise HS_X/HS_Y.
- Glyph coordinates are (offset >> S). Pixels that fall in a GAP column are 0.
- If the two fields overlap, each output is independent.

## Timing
- Reset values: score 0, hs_bcd 0, new_hs 0, blink_on 1, frame counter 0, score_pixel 0, hs_pixel 0.
- score_bcd, hs_bcd and new_hs update on the clock edge after the clear, inc or commit pulse.
- Pixel outputs have exactly one cycle of latency from h_cnt/v_cnt. They reflect the score and state as registered at that edge.
- Reset asserted mid-frame forces all outputs to 0 immediately. Rendering resumes on the first edge after release.
- frame_tick coinciding with commit: the blink counter still advances.
- Blink phase is not reset by commit.

## Structure
Shared package score_pkg holds:
- the 5×7 digit glyph function `glyph_px(digit, x, y)`, returning 0 for codes above 9;
- the state encodings;
- the glyph width/height constants.

One sub-module, bcd_counter_sat, holds DIGITS BCD digits and provides clear, inc, saturation and a `>` comparator output.
- The top level instantiates one of these for the score.
- hs_bcd is a plain register.

## Test plan
- Reset, then 1234 inc pulses → score_bcd = 16'h1234 and new_hs = 0.
- Score 9999 with DIGITS = 4, then inc → stays 16'h9999.
- clear and inc in the same cycle → score 0.
- hs = 0500, score 0499, commit together with inc → hs stays 0500 and score becomes 0500.
- A second commit at 0500 → no record.
- Score 0731, commit → hs_bcd = 16'h0731 and new_hs = 1.
- Same setup with 40 frame_ticks at BLINK_FRAMES = 16 → hs_pixel lit for frames 0–15, dark 16–31, lit 32–39.
- Score 0001 with SCALE_LOG2 = 1, raster sweep → pixels where expected for digit "1": score_pixel = 1 exactly at h_cnt ∈ {600, 601} (x = 4 of the ones digit, SC_X = 550) for v_cnt 20–33, each observed one clock after the counter value.
- state = 4 → hs field drawn at (120, 140) and nothing at (20, 20).
